// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and burst helpers, used by the arbiter, the interconnect and the masters.
package ahb_pkg;

    typedef enum logic [1:0] {
        H_IDLE   = 2'd0,
        H_BUSY   = 2'd1,
        H_NONSEQ = 2'd2,
        H_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0,
        HB_INCR   = 3'd1,
        HB_WRAP4  = 3'd2,
        HB_INCR4  = 3'd3,
        HB_WRAP8  = 3'd4,
        HB_INCR8  = 3'd5,
        HB_WRAP16 = 3'd6,
        HB_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_BURST = 2'd1,
        ST_LOCK  = 2'd2
    } arb_state_e;

    // Zero means the burst has no fixed length and may be re-arbitrated at any beat.
    function automatic logic [4:0] burst_len(input hburst_e b);
        case (b)
            HB_WRAP4, HB_INCR4:   return 5'd4;
            HB_WRAP8, HB_INCR8:   return 5'd8;
            HB_WRAP16, HB_INCR16: return 5'd16;
            default:              return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// Arbiter request/grant bundle: masters drive request, lock and the muxed address-phase controls.
interface ahb_arbiter_if #(
    parameter int MAT_NUM = 4
) ();
    localparam int MW = $clog2(MAT_NUM);

    logic [MAT_NUM-1:0]  hbusreq;
    logic [MAT_NUM-1:0]  hlock;
    ahb_pkg::htrans_e    htrans;
    ahb_pkg::hburst_e    hburst;
    logic                hready;
    logic [MAT_NUM-1:0]  hgrant;
    logic [MW-1:0]       hmaster;
    logic [MW-1:0]       hmaster_d;
    logic                hmastlock;

    modport master (
        output hbusreq, hlock, htrans, hburst, hready,
        input  hgrant, hmaster, hmaster_d, hmastlock
    );

    modport slave (
        input  hbusreq, hlock, htrans, hburst, hready,
        output hgrant, hmaster, hmaster_d, hmastlock
    );
endinterface

// File: rtl/ahb_arb_pick.sv
// Combinational one-hot picker: first set request bit at or after start, wrapping modulo N.
module ahb_arb_pick #(
    parameter int N  = 4,
    parameter int MW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [MW-1:0] start,
    output logic [N-1:0]  gnt,
    output logic          vld
);
    localparam int IW = MW + 1;

    logic [IW-1:0] idx;

    always_comb begin
        gnt = '0;
        vld = 1'b0;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, start} + IW'(i);
            if (idx >= IW'(N)) idx = idx - IW'(N);
            if (!vld && req[idx[MW-1:0]]) begin
                gnt[idx[MW-1:0]] = 1'b1;
                vld              = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ahb_arbiter.sv
// AHB-Lite bus arbiter: registered one-hot grant, address/data-phase owner indices, burst and lock protection.
// Fixed priority by default; round-robin when AHB_ARB_RR_EN is defined. Everything holds while hready is low.
module ahb_arbiter import ahb_pkg::*; #(
    parameter int MAT_NUM = 4,
    parameter int DEF_MST = 0
) (
    input  logic         hclk,
    input  logic         hresetn,
    ahb_arbiter_if.slave bus
);
    localparam int                  MW     = $clog2(MAT_NUM);
    localparam logic [MAT_NUM-1:0]  DEF_OH = MAT_NUM'(1) << DEF_MST;
    localparam logic [MW-1:0]       DEF_IX = MW'(DEF_MST);

    function automatic logic [MW-1:0] oh2idx(input logic [MAT_NUM-1:0] oh);
        logic [MW-1:0] r;
        r = '0;
        for (int i = 0; i < MAT_NUM; i++) begin
            if (oh[i]) r = r | MW'(i);
        end
        return r;
    endfunction

    arb_state_e          state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [MAT_NUM-1:0]  hgrant_q, hgrant_d;
    logic [MW-1:0]       hmaster_q, hmaster_d;
    logic [MW-1:0]       hmaster_d_q, hmaster_d_d;
    logic                hmastlock_q, hmastlock_d;

    logic [MW-1:0]       grant_idx;
    logic                lock_req;
    logic                is_idle, is_seq, is_nonseq, fixed;
    logic [4:0]          len;
    logic                arb_ok;
    logic [MAT_NUM-1:0]  pick_gnt;
    logic                pick_vld;
    logic [MW-1:0]       pick_start;

    assign grant_idx = oh2idx(hgrant_q);
    assign lock_req  = bus.hlock[grant_idx];
    assign is_idle   = (bus.htrans == H_IDLE);
    assign is_seq    = (bus.htrans == H_SEQ);
    assign is_nonseq = (bus.htrans == H_NONSEQ);
    assign len       = burst_len(bus.hburst);
    assign fixed     = (len != 5'd0);

    // The last SEQ of a fixed burst re-arbitrates so the next owner is granted for the following address phase.
    assign arb_ok = bus.hready && !lock_req &&
                    ((state_q == ST_ARB   && !(is_nonseq && fixed)) ||
                     (state_q == ST_BURST && is_seq && cnt_q == 5'd1));

    ahb_arb_pick #(.N(MAT_NUM), .MW(MW)) u_pick (
        .req   (bus.hbusreq),
        .start (pick_start),
        .gnt   (pick_gnt),
        .vld   (pick_vld)
    );

`ifdef AHB_ARB_RR_EN
    logic [MW-1:0] ptr_q, ptr_d;
    logic [MW-1:0] win_idx;

    assign win_idx    = oh2idx(pick_gnt);
    assign pick_start = ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (arb_ok && pick_vld) begin
            ptr_d = (win_idx == MW'(MAT_NUM - 1)) ? '0 : win_idx + MW'(1);
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end
`else
    assign pick_start = '0;
`endif

    // A nonzero count means a fixed burst is still in flight, including one started under lock.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hgrant_d    = hgrant_q;
        hmaster_d   = hmaster_q;
        hmaster_d_d = hmaster_d_q;
        hmastlock_d = hmastlock_q;
        if (bus.hready) begin
            hmaster_d   = grant_idx;
            hmaster_d_d = hmaster_q;
            hmastlock_d = lock_req;
            state_d     = (cnt_q != 5'd0) ? ST_BURST : ST_ARB;
            if (is_nonseq && fixed) begin
                cnt_d   = len - 5'd1;
                state_d = ST_BURST;
            end else if (is_nonseq || is_idle) begin
                cnt_d   = 5'd0;
                state_d = ST_ARB;
            end else if (is_seq && cnt_q != 5'd0) begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) state_d = ST_ARB;
            end
            if (lock_req) state_d = ST_LOCK;
            if (arb_ok)   hgrant_d = pick_vld ? pick_gnt : DEF_OH;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= ST_ARB;
            cnt_q       <= 5'd0;
            hgrant_q    <= DEF_OH;
            hmaster_q   <= DEF_IX;
            hmaster_d_q <= DEF_IX;
            hmastlock_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hgrant_q    <= hgrant_d;
            hmaster_q   <= hmaster_d;
            hmaster_d_q <= hmaster_d_d;
            hmastlock_q <= hmastlock_d;
        end
    end

    assign bus.hgrant    = hgrant_q;
    assign bus.hmaster   = hmaster_q;
    assign bus.hmaster_d = hmaster_d_q;
    assign bus.hmastlock = hmastlock_q;
endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed vector bench for ahb_arbiter with MAT_NUM=4, DEF_MST=0.
module tb_ahb_arbiter;
    import ahb_pkg::*;

    localparam int N = 4;

    logic hclk    = 1'b0;
    logic hresetn = 1'b0;

    ahb_arbiter_if #(.MAT_NUM(N)) bus ();

    ahb_arbiter #(.MAT_NUM(N), .DEF_MST(0)) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] lock;
        htrans_e    tr;
        hburst_e    bu;
        logic       rdy;
        logic [3:0] gnt;
        logic [1:0] m;
        logic [1:0] md;
        logic       ml;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic [3:0] req, input logic [3:0] lock, input htrans_e tr,
                                input hburst_e bu, input logic rdy, input logic [3:0] gnt,
                                input logic [1:0] m, input logic [1:0] md, input logic ml);
        vec_t r;
        r.req = req; r.lock = lock; r.tr = tr; r.bu = bu; r.rdy = rdy;
        r.gnt = gnt; r.m = m; r.md = md; r.ml = ml;
        return r;
    endfunction

    task automatic check(input string nm, input logic [3:0] gnt, input logic [1:0] m,
                         input logic [1:0] md, input logic ml);
        n_vec++;
        if ({bus.hgrant, bus.hmaster, bus.hmaster_d, bus.hmastlock} !== {gnt, m, md, ml}) begin
            n_err++;
            $display("FAIL %s: got hgrant=%b hmaster=%0d hmaster_d=%0d hmastlock=%b, want %b %0d %0d %b",
                     nm, bus.hgrant, bus.hmaster, bus.hmaster_d, bus.hmastlock, gnt, m, md, ml);
        end
    endtask

    task automatic run_vec(input vec_t t, input string nm);
        bus.hbusreq = t.req;
        bus.hlock   = t.lock;
        bus.htrans  = t.tr;
        bus.hburst  = t.bu;
        bus.hready  = t.rdy;
        @(posedge hclk);
        @(negedge hclk);
        check(nm, t.gnt, t.m, t.md, t.ml);
    endtask

    initial begin
        bus.hbusreq = '0;
        bus.hlock   = '0;
        bus.htrans  = H_IDLE;
        bus.hburst  = HB_SINGLE;
        bus.hready  = 1'b0;

`ifdef AHB_ARB_RR_EN
        // masters 1 and 2 alternate under round-robin
        tbl.push_back(mk(4'b0110, 4'b0000, H_NONSEQ, HB_SINGLE, 1, 4'b0010, 0, 0, 0));
        tbl.push_back(mk(4'b0110, 4'b0000, H_NONSEQ, HB_SINGLE, 1, 4'b0100, 1, 0, 0));
        tbl.push_back(mk(4'b0110, 4'b0000, H_NONSEQ, HB_SINGLE, 1, 4'b0010, 2, 1, 0));
        tbl.push_back(mk(4'b0110, 4'b0000, H_NONSEQ, HB_SINGLE, 1, 4'b0100, 1, 2, 0));
        tbl.push_back(mk(4'b0000, 4'b0000, H_IDLE,   HB_SINGLE, 1, 4'b0001, 2, 1, 0));
        tbl.push_back(mk(4'b0000, 4'b0000, H_IDLE,   HB_SINGLE, 1, 4'b0001, 0, 2, 0));
        tbl.push_back(mk(4'b0000, 4'b0000, H_IDLE,   HB_SINGLE, 1, 4'b0001, 0, 0, 0));
`else
        // fixed priority: 0 beats 3; no requests falls back to master 0
        tbl.push_back(mk(4'b1001, 4'b0000, H_IDLE,   HB_SINGLE, 1, 4'b0001, 0, 0, 0));
        tbl.push_back(mk(4'b1001, 4'b0000, H_NONSEQ, HB_SINGLE, 1, 4'b0001, 0, 0, 0));
        tbl.push_back(mk(4'b1000, 4'b0000, H_NONSEQ, HB_SINGLE, 1, 4'b1000, 0, 0, 0));
        tbl.push_back(mk(4'b1000, 4'b0000, H_NONSEQ, HB_SINGLE, 1, 4'b1000, 3, 0, 0));
        tbl.push_back(mk(4'b0000, 4'b0000, H_IDLE,   HB_SINGLE, 1, 4'b0001, 3, 3, 0));
        tbl.push_back(mk(4'b0000, 4'b0000, H_IDLE,   HB_SINGLE, 1, 4'b0001, 0, 3, 0));
        tbl.push_back(mk(4'b0000, 4'b0000, H_IDLE,   HB_SINGLE, 1, 4'b0001, 0, 0, 0));
`endif
        // master 2 INCR4, master 0 requests from beat 1; handover on beat 4
        tbl.push_back(mk(4'b0100, 4'b0000, H_IDLE,   HB_SINGLE, 1, 4'b0100, 0, 0, 0));
        tbl.push_back(mk(4'b0100, 4'b0000, H_IDLE,   HB_SINGLE, 1, 4'b0100, 2, 0, 0));
        tbl.push_back(mk(4'b0101, 4'b0000, H_NONSEQ, HB_INCR4,  1, 4'b0100, 2, 2, 0));
        tbl.push_back(mk(4'b0101, 4'b0000, H_SEQ,    HB_INCR4,  1, 4'b0100, 2, 2, 0));
        tbl.push_back(mk(4'b0101, 4'b0000, H_SEQ,    HB_INCR4,  1, 4'b0100, 2, 2, 0));
        tbl.push_back(mk(4'b0101, 4'b0000, H_SEQ,    HB_INCR4,  1, 4'b0001, 2, 2, 0));
        tbl.push_back(mk(4'b0001, 4'b0000, H_IDLE,   HB_SINGLE, 1, 4'b0001, 0, 2, 0));
        tbl.push_back(mk(4'b0001, 4'b0000, H_IDLE,   HB_SINGLE, 1, 4'b0001, 0, 0, 0));
        // master 1 INCR8 with a BUSY and two wait states; grant moves only on beat 8
        tbl.push_back(mk(4'b0010, 4'b0000, H_IDLE,   HB_SINGLE, 1, 4'b0010, 0, 0, 0));
        tbl.push_back(mk(4'b0010, 4'b0000, H_IDLE,   HB_SINGLE, 1, 4'b0010, 1, 0, 0));
        tbl.push_back(mk(4'b0011, 4'b0000, H_NONSEQ, HB_INCR8,  1, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(4'b0011, 4'b0000, H_SEQ,    HB_INCR8,  1, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(4'b0011, 4'b0000, H_BUSY,   HB_INCR8,  1, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(4'b0101, 4'b0000, H_SEQ,    HB_INCR8,  0, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(4'b0101, 4'b0000, H_SEQ,    HB_INCR8,  0, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(4'b0011, 4'b0000, H_SEQ,    HB_INCR8,  1, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(4'b0011, 4'b0000, H_SEQ,    HB_INCR8,  1, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(4'b0011, 4'b0000, H_SEQ,    HB_INCR8,  1, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(4'b0011, 4'b0000, H_SEQ,    HB_INCR8,  1, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(4'b0011, 4'b0000, H_SEQ,    HB_INCR8,  1, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(4'b0011, 4'b0000, H_SEQ,    HB_INCR8,  1, 4'b0001, 1, 1, 0));
        tbl.push_back(mk(4'b0001, 4'b0000, H_IDLE,   HB_SINGLE, 1, 4'b0001, 0, 1, 0));
        tbl.push_back(mk(4'b0001, 4'b0000, H_IDLE,   HB_SINGLE, 1, 4'b0001, 0, 0, 0));
        // master 3 locked over three NONSEQ while master 0 requests
        tbl.push_back(mk(4'b1000, 4'b1000, H_IDLE,   HB_SINGLE, 1, 4'b1000, 0, 0, 0));
        tbl.push_back(mk(4'b1001, 4'b1000, H_IDLE,   HB_SINGLE, 1, 4'b1000, 3, 0, 1));
        tbl.push_back(mk(4'b1001, 4'b1000, H_NONSEQ, HB_SINGLE, 1, 4'b1000, 3, 3, 1));
        tbl.push_back(mk(4'b1001, 4'b1000, H_NONSEQ, HB_SINGLE, 1, 4'b1000, 3, 3, 1));
        tbl.push_back(mk(4'b1001, 4'b1000, H_NONSEQ, HB_SINGLE, 1, 4'b1000, 3, 3, 1));
        tbl.push_back(mk(4'b1001, 4'b0000, H_NONSEQ, HB_SINGLE, 1, 4'b1000, 3, 3, 0));
        tbl.push_back(mk(4'b1001, 4'b0000, H_IDLE,   HB_SINGLE, 1, 4'b0001, 3, 3, 0));
        tbl.push_back(mk(4'b0001, 4'b0000, H_IDLE,   HB_SINGLE, 1, 4'b0001, 0, 3, 0));
        tbl.push_back(mk(4'b0001, 4'b0000, H_IDLE,   HB_SINGLE, 1, 4'b0001, 0, 0, 0));

        @(negedge hclk);
        @(negedge hclk);
        check("reset_state", 4'b0001, 0, 0, 1'b0);
        hresetn = 1'b1;

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // reset in the middle of an INCR4 must drop burst protection immediately
        run_vec(mk(4'b0100, 4'b0000, H_IDLE,   HB_SINGLE, 1, 4'b0100, 0, 0, 0), "mid_rst_grant");
        run_vec(mk(4'b0100, 4'b0000, H_IDLE,   HB_SINGLE, 1, 4'b0100, 2, 0, 0), "mid_rst_own");
        run_vec(mk(4'b0100, 4'b0000, H_NONSEQ, HB_INCR4,  1, 4'b0100, 2, 2, 0), "mid_rst_beat1");
        run_vec(mk(4'b0100, 4'b0000, H_SEQ,    HB_INCR4,  1, 4'b0100, 2, 2, 0), "mid_rst_beat2");
        hresetn = 1'b0;
        #1;
        check("mid_rst_async", 4'b0001, 0, 0, 1'b0);
        @(negedge hclk);
        check("mid_rst_hold", 4'b0001, 0, 0, 1'b0);
        hresetn = 1'b1;
        run_vec(mk(4'b0100, 4'b0000, H_SEQ,    HB_INCR4,  1, 4'b0100, 0, 0, 0), "mid_rst_rearb");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Bus arbiter sharing the single AHB-Lite address/data path between `MAT_NUM` masters ahead of the address decoder/interconnect. Samples master bus requests and lock, and issues a one-hot `hgrant`. Produces the address-phase owner index `hmaster` (drives the master-side address/control mux) and the data-phase owner index `hmaster_d` (routes `hrdata`/`hready`/`hresp` back). Fixed-length bursts and locked sequences are never broken.

## Interface
- `MAT_NUM`, 4, number of masters (2..16)
- `DEF_MST`, 0, default master granted when nobody requests
- `MW`, `$clog2(MAT_NUM)`, index width (derived, not overridden)
- `hclk  in  1  bus clock, all state on rising edge`
- `hresetn  in  1  asynchronous active-low reset`
- `hbusreq  in  MAT_NUM  per-master bus request`
- `hlock  in  MAT_NUM  per-master lock request`
- `htrans  in  2  transfer type of the muxed (current owner) address phase`
- `hburst  in  3  burst type of the muxed address phase`
- `hready  in  1  bus ready from the interconnect (`hready_o`)`
- `hgrant  out  MAT_NUM  one-hot grant, registered`
- `hmaster  out  MW  address-phase owner index`
- `hmaster_d  out  MW  data-phase owner index`
- `hmastlock  out  1  current address phase is locked`

## Operation
- Encodings: htrans IDLE=0, BUSY=1, NONSEQ=2, SEQ=3; hburst SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7.
- FSM `state`: ARB (re-arbitration allowed), BURST (fixed-length burst in flight), LOCK (granted master holds hlock).
- Beat counter `cnt` (5 bits). NONSEQ accepted (`hready`) with fixed-length hburst: `cnt` = len-1 (3/7/15), ARB -> BURST. SEQ accepted in BURST: `cnt` -1; at 0 -> ARB. BUSY: `cnt` held. IDLE or NONSEQ accepted in BURST (early termination): abort burst; NONSEQ reloads per its own hburst.
- SINGLE and INCR: no burst protection; arbitration after every accepted beat.
- `arb_ok` = `hready` and state ARB and not (accepting NONSEQ of a fixed-length burst); also true on the accepted SEQ with `cnt`==1 (last beat) so the next owner is granted in time for the following address phase.
- Lock: while `hlock[owner]` is 1, `arb_ok` is forced 0 (state LOCK); LOCK -> ARB on the first accepted transfer after `hlock[owner]` drops.
- Selection when `arb_ok`: among requesting masters, winner per Configuration; no request -> `DEF_MST`.
- `hmaster` <= index(`hgrant`) when `hready`; `hmaster_d` <= `hmaster` when `hready`; `hmastlock` <= `hlock[index(hgrant)]` when `hready`.
- Grant persists while owner keeps `hbusreq` and no higher-ranked winner exists at an `arb_ok` point.

## Timing
- Reset: `hgrant` = one-hot `DEF_MST`, `hmaster` = `hmaster_d` = `DEF_MST`, `hmastlock` = 0, state ARB, `cnt` = 0, RR pointer = 0.
- Request -> grant: 1 cycle (request sampled at edge with `arb_ok`, `hgrant` valid after it).
- Grant -> ownership: `hmaster` changes at first edge with `hready`=1 after `hgrant` changes; `hmaster_d` one accepted transfer later.
- `hready`=0: all registers hold; requests may change without effect.
- Reset mid-burst/lock: immediate return to reset values, no burst completion.

## Configuration
- `AHB_ARB_RR_EN` defined: round-robin; search starts at (last winner + 1) mod `MAT_NUM`; pointer updates only when a requesting master wins.
- Undefined: fixed priority, lowest index wins; pointer logic absent.

## Structure
- `ahb_pkg`: htrans/hburst enum typedefs and `burst_len(hburst)` function; shared with the interconnect and masters.
- Sub-module `ahb_arb_pick`: combinational one-hot picker (request vector, start pointer -> one-hot winner, valid), instantiated once.

## Test plan
- Reset with all inputs 0 -> `hgrant`=4'b0001, `hmaster`=0, `hmaster_d`=0, `hmastlock`=0.
- `AHB_ARB_RR_EN`, masters 1 and 2 requesting continuously, SINGLE NONSEQ each cycle -> grants alternate 1,2,1,2.
- Master 2 INCR4 burst, master 0 requests at beat 1 -> `hgrant` moves to 0 only on edge accepting SEQ beat 4; `hmaster`=0 on next `hready`.
- INCR8 with BUSY on beat 3 and `hready` low 2 cycles -> no grant change until 8th beat accepted.
- Master 3 with `hlock`=1 over three NONSEQ, master 0 requesting -> grant stays 3, `hmastlock`=1; released after lock drops.
- Macro undefined, masters 0 and 3 requesting -> master 0 always granted; all requests drop -> `DEF_MST` granted.
